stack_data_memory: RTL and testbench
====================================

Name: stack_data_memory

Overview:
- Parametrised data memory with a built-in hardware stack pointer.
- Serves the memory stage of the processor pipeline:
  - single-word LOAD/STORE by absolute address;
  - single-word PUSH/POP;
  - multi-word CALL/RET and INT/RTI sequences, which save and restore the two-word PC and the CCR.
- A sequencer FSM serialises multi-word operations onto one single-port RAM and reports completion through a valid/ready request and response handshake.
- Stack overflow and underflow are detected before any access is made.

Parameters:
- DATA_W, 16, memory word width; PC is 2*DATA_W bits (two words).
- ADDR_W, 12, address width; depth = 2**ADDR_W words.
- CCR_W, 3, condition-code width, zero-extended to DATA_W when stored (CCR_W <= DATA_W).
- SP_INIT, 2048, reset value of SP (stack empty).
- SP_LIMIT, 0, lowest SP value; a push with SP == SP_LIMIT is an overflow.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block idle and able to accept a request.
- req_op  in  3  0 LOAD, 1 STORE, 2 PUSH, 3 POP, 4 CALL, 5 RET, 6 INT, 7 RTI.
- req_addr  in  ADDR_W  address for LOAD/STORE.
- req_wdata  in  DATA_W  data for STORE/PUSH.
- req_pc  in  2*DATA_W  PC saved by CALL/INT.
- req_ccr  in  CCR_W  CCR saved by INT.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_err  out  1  qualifies rsp_valid: stack overflow or underflow, operation aborted.
- rsp_rdata  out  DATA_W  LOAD/POP result.
- rsp_pc  out  2*DATA_W  PC restored by RET/RTI.
- rsp_ccr  out  CCR_W  CCR restored by RTI (low CCR_W bits of the stored word).
- sp_out  out  ADDR_W  current SP.

Behaviour:
- Reset (rst low, any time, including mid-sequence):
  - FSM goes to IDLE; SP = SP_INIT.
  - req_ready = 0 while rst is low.
  - rsp_valid, rsp_err, rsp_rdata, rsp_pc, rsp_ccr all = 0.
  - RAM contents are not cleared.
  - Any in-flight sequence is abandoned; partial writes already made remain.
- Stack convention: full-descending, SP points to the next free slot.
  - Push: mem[SP] <= w; SP <= SP-1.
  - Pop: SP <= SP+1; read mem[SP+1].
  - Number of used slots = SP_INIT - SP.
- Handshake:
  - req_ready = 1 only in IDLE after reset release.
  - A request is accepted on the rising edge where req_valid && req_ready; operands are latched at that edge.
  - req_ready drops on the next cycle and returns high in the cycle rsp_valid is high.
- Word counts N and order:
  - LOAD, STORE, PUSH, POP: N = 1.
  - CALL: N = 2; pushes PC[hi] then PC[lo].
  - RET: N = 2; pops PC[lo] then PC[hi].
  - INT: N = 3; pushes PC[hi], PC[lo], then {0, CCR}.
  - RTI: N = 3; pops CCR, PC[lo], then PC[hi].
- Timing:
  - One RAM access per cycle.
  - Access k (k = 1..N) occurs at the k-th edge after acceptance.
  - rsp_valid is high during the cycle after edge N, so the request-to-response latency is N+1 cycles.
  - sp_out updates at each access edge.
- Response data:
  - rsp_rdata, rsp_pc and rsp_ccr hold their value until the next op that updates them.
  - STORE, PUSH, CALL and INT leave them unchanged.
- Error check, done at acceptance:
  - Overflow: a push-type op needs N slots and SP - SP_LIMIT < N.
  - Underflow: a pop-type op needs N words and SP_INIT - SP < N.
  - On error: no RAM access, SP unchanged, rsp_valid && rsp_err one cycle after acceptance (latency 1).
  - The error check never lets SP wrap around.
- LOAD/STORE use req_addr directly, with no range check, and never affect SP.
- RAM: synchronous write; read data is registered into the response registers. Read-after-write to the same address in consecutive operations returns the new data.

Test Plan:
- Reset:
  - Assert rst=0 mid-CALL (after the first word) -> sp_out=2048, req_ready=0 and rsp_valid=0 during reset.
  - After release, req_ready=1 and POP gives underflow (rsp_err=1, latency 1).
- STORE then LOAD:
  - STORE addr 0x123 data 0xBEEF, then LOAD 0x123 -> rsp_rdata=0xBEEF two cycles after the LOAD is accepted.
  - sp_out stays at 2048.
- PUSH and POP:
  - PUSH 0x1111, PUSH 0x2222 -> sp_out=2046.
  - POP -> 0x2222, then POP -> 0x1111; sp_out=2048.
- CALL then RET:
  - CALL pc=0x0001_0ABC -> mem[2048]=0x0001, mem[2047]=0x0ABC, sp_out=2046, rsp_valid 3 cycles after accept.
  - RET -> rsp_pc=0x00010ABC, sp_out=2048.
- INT then RTI:
  - INT pc=0xDEAD_BEEF, ccr=3'b101 -> three writes, sp_out=2045.
  - RTI -> rsp_ccr=3'b101, rsp_pc=0xDEADBEEF, latency 4, sp_out=2048.
- Overflow boundary (SP_INIT=4, SP_LIMIT=0):
  - Push 4 words -> sp_out=0.
  - A further PUSH -> rsp_err=1, sp_out=0, mem[0] unchanged.
  - CALL at sp_out=1 -> rsp_err=1.

Source files
------------

// File: rtl/stack_data_memory.sv
// Data memory with a hardware stack pointer; a two-state sequencer serialises
// single- and multi-word stack operations onto one single-port RAM.
module stack_data_memory #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 12,
  parameter int CCR_W    = 3,
  parameter int SP_INIT  = 2048,
  parameter int SP_LIMIT = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [2:0]          req_op,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [2*DATA_W-1:0] req_pc,
  input  logic [CCR_W-1:0]    req_ccr,
  output logic                rsp_valid,
  output logic                rsp_err,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic [2*DATA_W-1:0] rsp_pc,
  output logic [CCR_W-1:0]    rsp_ccr,
  output logic [ADDR_W-1:0]   sp_out
);

  localparam logic [2:0] OP_LOAD  = 3'd0;
  localparam logic [2:0] OP_STORE = 3'd1;
  localparam logic [2:0] OP_PUSH  = 3'd2;
  localparam logic [2:0] OP_POP   = 3'd3;
  localparam logic [2:0] OP_CALL  = 3'd4;
  localparam logic [2:0] OP_RET   = 3'd5;
  localparam logic [2:0] OP_INT   = 3'd6;
  localparam logic [2:0] OP_RTI   = 3'd7;

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W:0] SP_INIT_W  = (ADDR_W+1)'(SP_INIT);
  localparam logic [ADDR_W:0] SP_LIMIT_W = (ADDR_W+1)'(SP_LIMIT);

  typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_t;

  function automatic logic [1:0] op_words(input logic [2:0] op);
    case (op)
      OP_CALL, OP_RET: op_words = 2'd2;
      OP_INT, OP_RTI:  op_words = 2'd3;
      default:         op_words = 2'd1;
    endcase
  endfunction

  function automatic logic is_push(input logic [2:0] op);
    case (op)
      OP_PUSH, OP_CALL, OP_INT: is_push = 1'b1;
      default:                  is_push = 1'b0;
    endcase
  endfunction

  function automatic logic is_pop(input logic [2:0] op);
    case (op)
      OP_POP, OP_RET, OP_RTI: is_pop = 1'b1;
      default:                is_pop = 1'b0;
    endcase
  endfunction

  logic [DATA_W-1:0]   mem_r [DEPTH];

  state_t              state_r, state_s;
  logic                ready_r;
  logic [ADDR_W-1:0]   sp_r;
  logic [2:0]          op_r;
  logic [ADDR_W-1:0]   addr_r;
  logic [DATA_W-1:0]   wdata_r;
  logic [2*DATA_W-1:0] pc_r;
  logic [CCR_W-1:0]    ccr_r;
  logic [1:0]          step_r;
  logic [1:0]          nw_r;
  logic                rsp_valid_r;
  logic                rsp_err_r;
  logic [DATA_W-1:0]   rsp_rdata_r;
  logic [2*DATA_W-1:0] rsp_pc_r;
  logic [CCR_W-1:0]    rsp_ccr_r;

  logic                accept_s;
  logic [1:0]          req_nw_s;
  logic [ADDR_W:0]     used_s;
  logic [ADDR_W:0]     free_s;
  logic [ADDR_W:0]     req_nw_ext_s;
  logic                req_err_s;
  logic                last_s;
  logic                mem_we_s;
  logic [ADDR_W-1:0]   mem_addr_s;
  logic [DATA_W-1:0]   mem_wdata_s;
  logic [DATA_W-1:0]   ccr_ext_s;
  logic [ADDR_W-1:0]   sp_nxt_s;
  logic [DATA_W-1:0]   rd_s;

  // Acceptance and stack-bound check, evaluated against the current SP
  always_comb begin
    accept_s     = req_valid && ready_r;
    req_nw_s     = op_words(req_op);
    req_nw_ext_s = {{(ADDR_W-1){1'b0}}, req_nw_s};
    used_s       = SP_INIT_W - {1'b0, sp_r};
    free_s       = {1'b0, sp_r} - SP_LIMIT_W;
    if (is_push(req_op)) begin
      req_err_s = (free_s < req_nw_ext_s);
    end else if (is_pop(req_op)) begin
      req_err_s = (used_s < req_nw_ext_s);
    end else begin
      req_err_s = 1'b0;
    end
  end

  // Per-access address, write word and SP update for the current step
  always_comb begin
    last_s    = (step_r == nw_r);
    ccr_ext_s = {DATA_W{1'b0}};
    ccr_ext_s[CCR_W-1:0] = ccr_r;
    mem_we_s  = (state_r == ST_BUSY) && ((op_r == OP_STORE) || is_push(op_r));
    if ((op_r == OP_LOAD) || (op_r == OP_STORE)) begin
      mem_addr_s = addr_r;
      sp_nxt_s   = sp_r;
    end else if (is_push(op_r)) begin
      mem_addr_s = sp_r;
      sp_nxt_s   = sp_r - ADDR_W'(1);
    end else begin
      mem_addr_s = sp_r + ADDR_W'(1);
      sp_nxt_s   = sp_r + ADDR_W'(1);
    end
    // Pushes store the high PC word first so pops restore the low word first
    case (op_r)
      OP_CALL: mem_wdata_s = (step_r == 2'd1) ? pc_r[2*DATA_W-1:DATA_W] : pc_r[DATA_W-1:0];
      OP_INT: begin
        case (step_r)
          2'd1:    mem_wdata_s = pc_r[2*DATA_W-1:DATA_W];
          2'd2:    mem_wdata_s = pc_r[DATA_W-1:0];
          default: mem_wdata_s = ccr_ext_s;
        endcase
      end
      default: mem_wdata_s = wdata_r;
    endcase
    rd_s = mem_r[mem_addr_s];
  end

  // Next-state logic of the sequencer
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s && !req_err_s) begin
          state_s = ST_BUSY;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (last_s) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_BUSY;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Sequencer state, operand latches, SP and registered response
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= ST_IDLE;
      ready_r     <= 1'b0;
      sp_r        <= SP_INIT_W[ADDR_W-1:0];
      op_r        <= 3'd0;
      addr_r      <= {ADDR_W{1'b0}};
      wdata_r     <= {DATA_W{1'b0}};
      pc_r        <= {(2*DATA_W){1'b0}};
      ccr_r       <= {CCR_W{1'b0}};
      step_r      <= 2'd0;
      nw_r        <= 2'd0;
      rsp_valid_r <= 1'b0;
      rsp_err_r   <= 1'b0;
      rsp_rdata_r <= {DATA_W{1'b0}};
      rsp_pc_r    <= {(2*DATA_W){1'b0}};
      rsp_ccr_r   <= {CCR_W{1'b0}};
    end else begin
      state_r <= state_s;
      case (state_r)
        ST_IDLE: begin
          // A rejected request answers at once and leaves the block idle
          ready_r     <= !(accept_s && !req_err_s);
          rsp_valid_r <= accept_s && req_err_s;
          rsp_err_r   <= accept_s && req_err_s;
          op_r        <= req_op;
          addr_r      <= req_addr;
          wdata_r     <= req_wdata;
          pc_r        <= req_pc;
          ccr_r       <= req_ccr;
          step_r      <= 2'd1;
          nw_r        <= req_nw_s;
        end
        ST_BUSY: begin
          ready_r     <= last_s;
          rsp_valid_r <= last_s;
          rsp_err_r   <= 1'b0;
          step_r      <= step_r + 2'd1;
          sp_r        <= sp_nxt_s;
          case (op_r)
            OP_LOAD, OP_POP: rsp_rdata_r <= rd_s;
            OP_RET: begin
              if (step_r == 2'd1) rsp_pc_r[DATA_W-1:0] <= rd_s;
              else rsp_pc_r[2*DATA_W-1:DATA_W] <= rd_s;
            end
            OP_RTI: begin
              case (step_r)
                2'd1:    rsp_ccr_r <= rd_s[CCR_W-1:0];
                2'd2:    rsp_pc_r[DATA_W-1:0] <= rd_s;
                default: rsp_pc_r[2*DATA_W-1:DATA_W] <= rd_s;
              endcase
            end
            default: rsp_rdata_r <= rsp_rdata_r;
          endcase
        end
        default: begin
          ready_r     <= 1'b0;
          rsp_valid_r <= 1'b0;
          rsp_err_r   <= 1'b0;
        end
      endcase
    end
  end

  // RAM array: synchronous write, contents survive reset
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_r[mem_addr_s] <= mem_wdata_s;
    end
  end

  assign req_ready = ready_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_err   = rsp_err_r;
  assign rsp_rdata = rsp_rdata_r;
  assign rsp_pc    = rsp_pc_r;
  assign rsp_ccr   = rsp_ccr_r;
  assign sp_out    = sp_r;

endmodule

// File: tb/tb_stack_data_memory.sv
// Table-driven bench for stack_data_memory: a default instance and a tiny-stack
// instance (SP_INIT=4) for the overflow boundary, checked through a scoreboard.
module tb_stack_data_memory;

  localparam logic [2:0] LOAD = 3'd0, STORE = 3'd1, PUSH = 3'd2, POP = 3'd3;
  localparam logic [2:0] CALL = 3'd4, RET = 3'd5, INT = 3'd6, RTI = 3'd7;

  typedef struct {
    logic        dut;
    logic [2:0]  op;
    logic [11:0] addr;
    logic [15:0] wdata;
    logic [31:0] pc;
    logic [2:0]  ccr;
    logic        xerr;
    logic [15:0] xrdata;
    logic [31:0] xpc;
    logic [2:0]  xccr;
    logic [11:0] xsp;
    int          xlat;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        valid_a, valid_b;
  logic [2:0]  op;
  logic [11:0] addr;
  logic [15:0] wdata;
  logic [31:0] pc;
  logic [2:0]  ccr;

  logic        a_ready, a_valid, a_err;
  logic [15:0] a_rdata;
  logic [31:0] a_pc;
  logic [2:0]  a_ccr;
  logic [11:0] a_sp;
  logic        b_ready, b_valid, b_err;
  logic [15:0] b_rdata;
  logic [31:0] b_pc;
  logic [2:0]  b_ccr;
  logic [3:0]  b_sp;

  stack_data_memory dut_a (
    .clk(clk), .rst(rst), .req_valid(valid_a), .req_ready(a_ready), .req_op(op),
    .req_addr(addr), .req_wdata(wdata), .req_pc(pc), .req_ccr(ccr),
    .rsp_valid(a_valid), .rsp_err(a_err), .rsp_rdata(a_rdata), .rsp_pc(a_pc),
    .rsp_ccr(a_ccr), .sp_out(a_sp)
  );

  stack_data_memory #(.ADDR_W(4), .SP_INIT(4), .SP_LIMIT(0)) dut_b (
    .clk(clk), .rst(rst), .req_valid(valid_b), .req_ready(b_ready), .req_op(op),
    .req_addr(addr[3:0]), .req_wdata(wdata), .req_pc(pc), .req_ccr(ccr),
    .rsp_valid(b_valid), .rsp_err(b_err), .rsp_rdata(b_rdata), .rsp_pc(b_pc),
    .rsp_ccr(b_ccr), .sp_out(b_sp)
  );

  logic        sel;
  logic        obs_ready, obs_valid, obs_err;
  logic [15:0] obs_rdata;
  logic [31:0] obs_pc;
  logic [2:0]  obs_ccr;
  logic [11:0] obs_sp;
  assign obs_ready = sel ? b_ready : a_ready;
  assign obs_valid = sel ? b_valid : a_valid;
  assign obs_err   = sel ? b_err   : a_err;
  assign obs_rdata = sel ? b_rdata : a_rdata;
  assign obs_pc    = sel ? b_pc    : a_pc;
  assign obs_ccr   = sel ? b_ccr   : a_ccr;
  assign obs_sp    = sel ? {8'd0, b_sp} : a_sp;

  int   n_chk = 0;
  int   n_fail = 0;
  vec_t tbl[$];
  vec_t sb[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h, required 0x%0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic d, input logic [2:0] o, input logic [11:0] a,
                              input logic [15:0] w, input logic [31:0] p, input logic [2:0] c,
                              input logic e, input logic [15:0] xr, input logic [31:0] xp,
                              input logic [2:0] xc, input logic [11:0] xs, input int l);
    vec_t v;
    v.dut = d; v.op = o; v.addr = a; v.wdata = w; v.pc = p; v.ccr = c;
    v.xerr = e; v.xrdata = xr; v.xpc = xp; v.xccr = xc; v.xsp = xs; v.xlat = l;
    return v;
  endfunction

  // Drive one request, queue its expectation, and check the response against it
  task automatic run_vec(input vec_t v);
    int   w;
    int   lat;
    logic got;
    vec_t e;
    sel = v.dut;
    w = 0;
    while (obs_ready !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("req_ready_before_request", {31'd0, obs_ready}, 32'd1);
    op = v.op; addr = v.addr; wdata = v.wdata; pc = v.pc; ccr = v.ccr;
    if (v.dut) valid_b = 1'b1; else valid_a = 1'b1;
    sb.push_back(v);
    @(posedge clk);
    lat = 0;
    got = 1'b0;
    while (!got && lat < 20) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        valid_a = 1'b0;
        valid_b = 1'b0;
      end
      if (obs_valid === 1'b1) got = 1'b1;
    end
    e = sb.pop_front();
    if (!got) begin
      n_chk++;
      n_fail++;
      $display("FAIL rsp_timeout: op %0d no rsp_valid after %0d cycles, required latency %0d", e.op, lat, e.xlat);
    end else begin
      chk("rsp_err",   {31'd0, obs_err}, {31'd0, e.xerr});
      chk("rsp_rdata", {16'd0, obs_rdata}, {16'd0, e.xrdata});
      chk("rsp_pc",    obs_pc, e.xpc);
      chk("rsp_ccr",   {29'd0, obs_ccr}, {29'd0, e.xccr});
      chk("sp_out",    {20'd0, obs_sp}, {20'd0, e.xsp});
      chk("latency",   lat, e.xlat);
      chk("req_ready_at_rsp", {31'd0, obs_ready}, 32'd1);
      @(negedge clk);
      chk("rsp_valid_pulse", {31'd0, obs_valid}, 32'd0);
    end
  endtask

  initial begin
    rst = 1'b0; valid_a = 1'b0; valid_b = 1'b0; sel = 1'b0;
    op = LOAD; addr = 12'd0; wdata = 16'd0; pc = 32'd0; ccr = 3'd0;
    repeat (3) @(negedge clk);
    chk("reset_sp_a",    {20'd0, a_sp}, 32'd2048);
    chk("reset_sp_b",    {28'd0, b_sp}, 32'd4);
    chk("reset_ready_a", {31'd0, a_ready}, 32'd0);
    chk("reset_valid_a", {31'd0, a_valid}, 32'd0);
    chk("reset_err_a",   {31'd0, a_err}, 32'd0);
    chk("reset_rdata_a", {16'd0, a_rdata}, 32'd0);
    chk("reset_pc_a",    a_pc, 32'd0);
    rst = 1'b1;

    // Default instance: underflow, STORE/LOAD, PUSH/POP, CALL/RET, INT/RTI
    tbl.push_back(mk(1'b0, POP,   12'h000, 16'h0000, 32'h0,         3'd0, 1'b1, 16'h0000, 32'h0,         3'd0, 12'd2048, 1));
    tbl.push_back(mk(1'b0, STORE, 12'h123, 16'hBEEF, 32'h0,         3'd0, 1'b0, 16'h0000, 32'h0,         3'd0, 12'd2048, 2));
    tbl.push_back(mk(1'b0, LOAD,  12'h123, 16'h0000, 32'h0,         3'd0, 1'b0, 16'hBEEF, 32'h0,         3'd0, 12'd2048, 2));
    tbl.push_back(mk(1'b0, PUSH,  12'h000, 16'h1111, 32'h0,         3'd0, 1'b0, 16'hBEEF, 32'h0,         3'd0, 12'd2047, 2));
    tbl.push_back(mk(1'b0, PUSH,  12'h000, 16'h2222, 32'h0,         3'd0, 1'b0, 16'hBEEF, 32'h0,         3'd0, 12'd2046, 2));
    tbl.push_back(mk(1'b0, POP,   12'h000, 16'h0000, 32'h0,         3'd0, 1'b0, 16'h2222, 32'h0,         3'd0, 12'd2047, 2));
    tbl.push_back(mk(1'b0, POP,   12'h000, 16'h0000, 32'h0,         3'd0, 1'b0, 16'h1111, 32'h0,         3'd0, 12'd2048, 2));
    tbl.push_back(mk(1'b0, CALL,  12'h000, 16'h0000, 32'h00010ABC,  3'd0, 1'b0, 16'h1111, 32'h0,         3'd0, 12'd2046, 3));
    tbl.push_back(mk(1'b0, LOAD,  12'h800, 16'h0000, 32'h0,         3'd0, 1'b0, 16'h0001, 32'h0,         3'd0, 12'd2046, 2));
    tbl.push_back(mk(1'b0, LOAD,  12'h7FF, 16'h0000, 32'h0,         3'd0, 1'b0, 16'h0ABC, 32'h0,         3'd0, 12'd2046, 2));
    tbl.push_back(mk(1'b0, RET,   12'h000, 16'h0000, 32'h0,         3'd0, 1'b0, 16'h0ABC, 32'h00010ABC,  3'd0, 12'd2048, 3));
    tbl.push_back(mk(1'b0, INT,   12'h000, 16'h0000, 32'hDEADBEEF,  3'd5, 1'b0, 16'h0ABC, 32'h00010ABC,  3'd0, 12'd2045, 4));
    tbl.push_back(mk(1'b0, LOAD,  12'h7FE, 16'h0000, 32'h0,         3'd0, 1'b0, 16'h0005, 32'h00010ABC,  3'd0, 12'd2045, 2));
    tbl.push_back(mk(1'b0, RTI,   12'h000, 16'h0000, 32'h0,         3'd0, 1'b0, 16'h0005, 32'hDEADBEEF,  3'd5, 12'd2048, 4));
    tbl.push_back(mk(1'b0, RET,   12'h000, 16'h0000, 32'h0,         3'd0, 1'b1, 16'h0005, 32'hDEADBEEF,  3'd5, 12'd2048, 1));
    tbl.push_back(mk(1'b0, RTI,   12'h000, 16'h0000, 32'h0,         3'd0, 1'b1, 16'h0005, 32'hDEADBEEF,  3'd5, 12'd2048, 1));
    tbl.push_back(mk(1'b0, LOAD,  12'h800, 16'h0000, 32'h0,         3'd0, 1'b0, 16'hDEAD, 32'hDEADBEEF,  3'd5, 12'd2048, 2));
    // Tiny stack: fill to SP_LIMIT, then overflow on PUSH, CALL and INT
    tbl.push_back(mk(1'b1, STORE, 12'h000, 16'h0F0F, 32'h0,         3'd0, 1'b0, 16'h0000, 32'h0,         3'd0, 12'd4, 2));
    tbl.push_back(mk(1'b1, PUSH,  12'h000, 16'h00A0, 32'h0,         3'd0, 1'b0, 16'h0000, 32'h0,         3'd0, 12'd3, 2));
    tbl.push_back(mk(1'b1, PUSH,  12'h000, 16'h00A1, 32'h0,         3'd0, 1'b0, 16'h0000, 32'h0,         3'd0, 12'd2, 2));
    tbl.push_back(mk(1'b1, PUSH,  12'h000, 16'h00A2, 32'h0,         3'd0, 1'b0, 16'h0000, 32'h0,         3'd0, 12'd1, 2));
    tbl.push_back(mk(1'b1, PUSH,  12'h000, 16'h00A3, 32'h0,         3'd0, 1'b0, 16'h0000, 32'h0,         3'd0, 12'd0, 2));
    tbl.push_back(mk(1'b1, PUSH,  12'h000, 16'h5555, 32'h0,         3'd0, 1'b1, 16'h0000, 32'h0,         3'd0, 12'd0, 1));
    tbl.push_back(mk(1'b1, LOAD,  12'h000, 16'h0000, 32'h0,         3'd0, 1'b0, 16'h0F0F, 32'h0,         3'd0, 12'd0, 2));
    tbl.push_back(mk(1'b1, POP,   12'h000, 16'h0000, 32'h0,         3'd0, 1'b0, 16'h00A3, 32'h0,         3'd0, 12'd1, 2));
    tbl.push_back(mk(1'b1, CALL,  12'h000, 16'h0000, 32'h12345678,  3'd0, 1'b1, 16'h00A3, 32'h0,         3'd0, 12'd1, 1));
    tbl.push_back(mk(1'b1, INT,   12'h000, 16'h0000, 32'h12345678,  3'd2, 1'b1, 16'h00A3, 32'h0,         3'd0, 12'd1, 1));
    tbl.push_back(mk(1'b1, PUSH,  12'h000, 16'h6666, 32'h0,         3'd0, 1'b0, 16'h00A3, 32'h0,         3'd0, 12'd0, 2));
    tbl.push_back(mk(1'b1, POP,   12'h000, 16'h0000, 32'h0,         3'd0, 1'b0, 16'h6666, 32'h0,         3'd0, 12'd1, 2));

    for (int i = 0; i < tbl.size(); i++) begin
      run_vec(tbl[i]);
    end

    // Reset in the middle of a CALL, after its first word has been written
    sel = 1'b0;
    op = CALL; pc = 32'h1234_5678; valid_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid_a = 1'b0;
    @(posedge clk);
    #1;
    chk("midcall_sp_first_word", {20'd0, a_sp}, 32'd2047);
    #1 rst = 1'b0;
    #1;
    chk("midcall_reset_sp",    {20'd0, a_sp}, 32'd2048);
    chk("midcall_reset_ready", {31'd0, a_ready}, 32'd0);
    chk("midcall_reset_valid", {31'd0, a_valid}, 32'd0);
    repeat (2) @(negedge clk);
    chk("midcall_hold_sp",     {20'd0, a_sp}, 32'd2048);
    chk("midcall_hold_ready",  {31'd0, a_ready}, 32'd0);
    chk("midcall_hold_valid",  {31'd0, a_valid}, 32'd0);
    chk("midcall_rsp_pc",      a_pc, 32'd0);
    chk("midcall_rsp_ccr",     {29'd0, a_ccr}, 32'd0);
    rst = 1'b1;
    run_vec(mk(1'b0, POP,  12'h000, 16'h0000, 32'h0, 3'd0, 1'b1, 16'h0000, 32'h0, 3'd0, 12'd2048, 1));
    run_vec(mk(1'b0, LOAD, 12'h800, 16'h0000, 32'h0, 3'd0, 1'b0, 16'h1234, 32'h0, 3'd0, 12'd2048, 2));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
